// File: rtl/arm_pkg.sv
// Shared definitions for the block-transfer sequencer: FSM state encoding,
// instruction bit positions used by LDM/STM and the PC register index.
package arm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        WBACK = 3'd3,
        DONE  = 3'd4
    } xfer_state_e;

    localparam int IR_P = 24;
    localparam int IR_U = 23;
    localparam int IR_W = 21;
    localparam int IR_L = 20;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage : arm_pkg

// File: rtl/lowest_set_bit16.sv
// Priority encoder: index of the lowest set bit of a 16-bit register list.
// idx_o is 0 when the list is empty; valid_o flags a non-empty list.
module lowest_set_bit16 (
    input  logic [15:0] vec_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        idx_o   = 4'd0;
        valid_o = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = 4'(i);
                valid_o = 1'b1;
            end else begin
                idx_o   = idx_o;
                valid_o = valid_o;
            end
        end
    end

endmodule : lowest_set_bit16

// File: rtl/block_xfer_seq.sv
// LDM/STM multi-register transfer sequencer.
// Walks the register list lowest register first, one beat per accepted
// mem_ready, on ascending word addresses, then optionally writes back the
// base register. All outputs are registered except reg_we/pc_loaded, which
// must coincide with the mem_ready cycle of a load beat.
// Optional feature: define BLOCK_XFER_ABORT_EN to add mem_abort/aborted.
module block_xfer_seq
    import arm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_B = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       IR,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              mem_ready,
`ifdef BLOCK_XFER_ABORT_EN
    input  logic              mem_abort,
    output logic              aborted,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        reg_idx,
    output logic              reg_we,
    output logic              wb_we,
    output logic [3:0]        wb_idx,
    output logic [ADDR_W-1:0] wb_data,
    output logic              pc_loaded
);

    xfer_state_e       state_q, state_d;
    logic [15:0]       list_q, list_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0]        rn_q, rn_d;
    logic              p_q, p_d, u_q, u_d, w_q, w_d, l_q, l_d;
    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] final_q, final_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        reg_idx_q, reg_idx_d;
    logic              wb_we_q, wb_we_d;
`ifdef BLOCK_XFER_ABORT_EN
    logic              aborted_q, aborted_d;
`endif

    logic [4:0]        pop_s;
    logic [ADDR_W-1:0] span_s;
    logic [ADDR_W-1:0] start_addr_s;
    logic [ADDR_W-1:0] final_s;
    logic [15:0]       list_clr_s;
    logic [15:0]       lsb_in_s;
    logic [3:0]        lsb_idx_s;
    logic              unused_lsb_valid_s;
    logic              abort_s;
    logic              unused_ir_s;

    assign unused_ir_s = ^{IR[31:25], IR[22]};

`ifdef BLOCK_XFER_ABORT_EN
    assign abort_s = mem_abort;
`else
    assign abort_s = 1'b0;
`endif

    // Working list with its lowest register removed (the beat just accepted).
    assign list_clr_s = list_q & (list_q - 16'd1);

    // In SETUP pick the first register; in XFER pick the one after the current beat.
    assign lsb_in_s = (state_q == XFER) ? list_clr_s : list_q;

    lowest_set_bit16 u_lsb (
        .vec_i   (lsb_in_s),
        .idx_o   (lsb_idx_s),
        .valid_o (unused_lsb_valid_s)
    );

    // Popcount of the latched register list (adder chain, used in SETUP only).
    always_comb begin
        pop_s = 5'd0;
        for (int i = 0; i < 16; i++) begin
            pop_s = pop_s + {4'd0, list_q[i]};
        end
    end

    // Lowest beat address and final base from P/U; arithmetic wraps mod 2^ADDR_W.
    always_comb begin
        span_s = ADDR_W'(pop_s) * ADDR_W'(WORD_B);
        case ({p_q, u_q})
            2'b01:   start_addr_s = base_q;                                 // IA
            2'b11:   start_addr_s = base_q + ADDR_W'(WORD_B);               // IB
            2'b00:   start_addr_s = base_q - span_s + ADDR_W'(WORD_B);      // DA
            2'b10:   start_addr_s = base_q - span_s;                        // DB
            default: start_addr_s = base_q;
        endcase
        if (u_q) begin
            final_s = base_q + span_s;
        end else begin
            final_s = base_q - span_s;
        end
    end

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        list_d     = list_q;
        base_d     = base_q;
        rn_d       = rn_q;
        p_d        = p_q;
        u_d        = u_q;
        w_d        = w_q;
        l_d        = l_q;
        wb_en_d    = wb_en_q;
        final_d    = final_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = {ADDR_W{1'b0}};
        reg_idx_d  = 4'd0;
        wb_we_d    = 1'b0;
`ifdef BLOCK_XFER_ABORT_EN
        aborted_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    list_d  = IR[15:0];
                    base_d  = base_addr;
                    rn_d    = IR[19:16];
                    p_d     = IR[IR_P];
                    u_d     = IR[IR_U];
                    w_d     = IR[IR_W];
                    l_d     = IR[IR_L];
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                final_d = final_s;
                // A load that includes Rn keeps the loaded value, not the writeback.
                wb_en_d = w_q & ~(l_q & list_q[rn_q]);
                if (pop_s == 5'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = XFER;
                    busy_d     = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_we_d   = ~l_q;
                    mem_addr_d = start_addr_s;
                    reg_idx_d  = lsb_idx_s;
                end
            end
            XFER: begin
                busy_d     = 1'b1;
                mem_req_d  = 1'b1;
                mem_we_d   = mem_we_q;
                mem_addr_d = mem_addr_q;
                reg_idx_d  = reg_idx_q;
                if (mem_ready && abort_s) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_addr_d = {ADDR_W{1'b0}};
                    reg_idx_d = 4'd0;
                    list_d    = 16'd0;
`ifdef BLOCK_XFER_ABORT_EN
                    aborted_d = 1'b1;
`endif
                end else if (mem_ready) begin
                    list_d = list_clr_s;
                    if (list_clr_s == 16'd0) begin
                        state_d    = WBACK;
                        mem_req_d  = 1'b0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {ADDR_W{1'b0}};
                        reg_idx_d  = 4'd0;
                        wb_we_d    = wb_en_q;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_W'(WORD_B);
                        reg_idx_d  = lsb_idx_s;
                    end
                end else begin
                    state_d = XFER;
                end
            end
            WBACK: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched operands and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            list_q     <= 16'd0;
            base_q     <= {ADDR_W{1'b0}};
            rn_q       <= 4'd0;
            p_q        <= 1'b0;
            u_q        <= 1'b0;
            w_q        <= 1'b0;
            l_q        <= 1'b0;
            wb_en_q    <= 1'b0;
            final_q    <= {ADDR_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {ADDR_W{1'b0}};
            reg_idx_q  <= 4'd0;
            wb_we_q    <= 1'b0;
`ifdef BLOCK_XFER_ABORT_EN
            aborted_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            base_q     <= base_d;
            rn_q       <= rn_d;
            p_q        <= p_d;
            u_q        <= u_d;
            w_q        <= w_d;
            l_q        <= l_d;
            wb_en_q    <= wb_en_d;
            final_q    <= final_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            reg_idx_q  <= reg_idx_d;
            wb_we_q    <= wb_we_d;
`ifdef BLOCK_XFER_ABORT_EN
            aborted_q  <= aborted_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign reg_idx   = reg_idx_q;
    assign wb_we     = wb_we_q;
    assign wb_idx    = rn_q;
    assign wb_data   = final_q;
    assign reg_we    = mem_req_q & ~mem_we_q & mem_ready & ~abort_s;
    assign pc_loaded = reg_we & (reg_idx_q == REG_PC);
`ifdef BLOCK_XFER_ABORT_EN
    assign aborted   = aborted_q;
`endif

endmodule : block_xfer_seq

// File: tb/tb_block_xfer_seq.sv
// Self-checking bench for block_xfer_seq: directed LDM/STM cases plus
// randomized transfers against a list/address reference model.
module tb_block_xfer_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] IR = 32'd0;
    logic [31:0] base_addr = 32'd0;
    logic        mem_ready = 1'b0;
    logic        busy, done, mem_req, mem_we, reg_we, wb_we, pc_loaded;
    logic [31:0] mem_addr, wb_data;
    logic [3:0]  reg_idx, wb_idx;
`ifdef BLOCK_XFER_ABORT_EN
    logic        mem_abort = 1'b0;
    logic        aborted;
`endif

    int compared = 0;
    int mismatched = 0;
    int          exp_reg[$];
    logic [31:0] exp_addr[$];

    block_xfer_seq #(.ADDR_W(32), .WORD_B(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .IR(IR), .base_addr(base_addr),
        .mem_ready(mem_ready),
`ifdef BLOCK_XFER_ABORT_EN
        .mem_abort(mem_abort), .aborted(aborted),
`endif
        .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .reg_idx(reg_idx), .reg_we(reg_we), .wb_we(wb_we),
        .wb_idx(wb_idx), .wb_data(wb_data), .pc_loaded(pc_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 32'd0);
        check({tag, "_done"}, done, 32'd0);
        check({tag, "_mem_req"}, mem_req, 32'd0);
        check({tag, "_mem_we"}, mem_we, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_reg_idx"}, reg_idx, 32'd0);
        check({tag, "_reg_we"}, reg_we, 32'd0);
        check({tag, "_wb_we"}, wb_we, 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_pc_loaded"}, pc_loaded, 32'd0);
    endtask

    // One complete transfer: model the expected beats, drive, and check every cycle.
    task automatic run_xfer(input logic [31:0] ir, input logic [31:0] base,
                            input int stall_beat, input int stall_len,
                            input bit rand_ready, input bit poke_start);
        logic [15:0] lst;
        logic [31:0] lowest, final_b;
        int n, k, beats, last_c, stall_cnt;
        bit exp_wb, got_done, wb_seen, first_seen, ld;
        lst = ir[15:0];
        ld = ir[20];
        exp_reg.delete();
        exp_addr.delete();
        n = 0;
        for (int i = 0; i < 16; i++) if (lst[i]) n++;
        if (ir[23]) lowest = ir[24] ? base + 32'd4 : base;
        else        lowest = ir[24] ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
        final_b = ir[23] ? base + 32'(4 * n) : base - 32'(4 * n);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (lst[i]) begin
                exp_reg.push_back(i);
                exp_addr.push_back(lowest + 32'(4 * k));
                k++;
            end
        end
        exp_wb = (n > 0) && ir[21] && !(ir[20] && lst[ir[19:16]]);
        beats = 0; last_c = 0; stall_cnt = 0;
        got_done = 0; wb_seen = 0; first_seen = 0;

        @(posedge clk); #1;
        start = 1'b1; IR = ir; base_addr = base; mem_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; IR = $urandom; base_addr = $urandom;
        for (int c = 1; c <= 300; c++) begin
            if (rand_ready) begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end else if (beats == stall_beat && stall_cnt < stall_len) begin
                mem_ready = 1'b0;
                stall_cnt++;
            end else begin
                mem_ready = 1'b1;
            end
            start = (poke_start && c == 3) ||
                    (n == 0 ? (c == 2) : (beats == n && c == last_c + 2));
            @(negedge clk);
            if (done) begin
                got_done = 1;
                check("done_busy", busy, 32'd0);
                check("done_cycle", c, (n == 0) ? 32'd2 : 32'(last_c + 2));
                check("beat_total", beats, n);
                check("wb_seen", wb_seen, exp_wb);
                check("done_mem_req", mem_req, 32'd0);
                break;
            end
            check("busy", busy, 32'd1);
            if (mem_req) begin
                check("queue_avail", exp_reg.size() > 0, 32'd1);
                if (exp_reg.size() > 0) begin
                    if (!first_seen) check("first_req_cycle", c, 32'd2);
                    first_seen = 1;
                    check("reg_idx", reg_idx, exp_reg[0]);
                    check("mem_addr", mem_addr, exp_addr[0]);
                    check("mem_we", mem_we, !ld);
                    check("reg_we", reg_we, mem_ready && ld);
                    check("pc_loaded", pc_loaded, mem_ready && ld && exp_reg[0] == 15);
                    if (mem_ready) begin
                        void'(exp_reg.pop_front());
                        void'(exp_addr.pop_front());
                        beats++;
                        last_c = c;
                    end
                end
            end else begin
                check("reg_we_idle", reg_we, 32'd0);
                check("pc_loaded_idle", pc_loaded, 32'd0);
            end
            if (wb_we) begin
                wb_seen = 1;
                check("wb_data", wb_data, final_b);
                check("wb_idx", wb_idx, ir[19:16]);
                check("wb_cycle", c, 32'(last_c + 1));
            end
            @(posedge clk); #1;
        end
        check("done_seen", got_done, 32'd1);
        // A start presented in the DONE cycle must not launch a new sequence.
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            mem_ready = 1'b0;
            @(negedge clk);
            check("post_idle_busy", busy, 32'd0);
            check("post_idle_req", mem_req, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rir;
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // LDMIA r5!, {r0-r3}
        run_xfer(32'h00B5_000F, 32'h0000_0100, -1, 0, 1'b0, 1'b0);
        // STMDB r13!, {r0,r4,r15}
        run_xfer(32'h012D_8011, 32'h0000_0200, -1, 0, 1'b0, 1'b0);
        // LDMIB r2!, {r1,r2}: base in list, no writeback
        run_xfer(32'h01B2_0006, 32'h0000_0040, -1, 0, 1'b0, 1'b0);
        // Three-cycle stall on the second beat
        run_xfer(32'h00B0_00F0, 32'h0000_1000, 1, 3, 1'b0, 1'b0);
        // Empty list, with a start poked while busy
        run_xfer(32'h00B3_0000, 32'h0000_0300, -1, 0, 1'b0, 1'b1);
        // STMDB full list wrapping below zero
        run_xfer(32'h012E_FFFF, 32'h0000_0008, -1, 0, 1'b0, 1'b0);
        // LDMIA including PC, no writeback
        run_xfer(32'h0091_8003, 32'hFFFF_FFF8, -1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            rir = $urandom;
            if ($urandom_range(0, 7) == 0) rir[15:0] = 16'd0;
            run_xfer(rir, $urandom, -1, 0, 1'b1, $urandom_range(0, 1) == 1);
        end

        // Reset during beat 2 of a 4-beat load: outputs clear at once, no writeback.
        @(posedge clk); #1;
        start = 1'b1; IR = 32'h00B3_00F0; base_addr = 32'h0000_2000; mem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_req", mem_req, 32'd1);
        check("rst_pre_idx", reg_idx, 32'd5);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("postrst_wb_we", wb_we, 32'd0);
            check("postrst_busy", busy, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_block_xfer_seq
